// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver with integrated baud timing.
//            Configurable data width, optional even/odd parity, 1 or 2 stop
//            bits. Reports parity, framing and (sticky) overrun errors and
//            delivers words over a valid/ready handshake.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            uart_rx    - serial line, idle high, LSB first
//            rx_data    - received word, stable while rx_valid = 1
//            rx_valid   - word available, held until accepted
//            rx_ready   - consumer accepts when rx_valid & rx_ready
//            parity_err - parity mismatch on rx_data (qualified by rx_valid)
//            frame_err  - a stop bit sampled low (qualified by rx_valid)
//            overrun    - sticky, a frame completed while a word was pending
//            rx_busy    - high from start-bit detection to end of last stop
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int CLK_DIV     = 217,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int c_TIMER_W = $clog2(CLK_DIV);
  localparam int c_BIT_W   = $clog2(DATA_BITS + 1);

  localparam logic [c_TIMER_W-1:0] c_FULL_M1  = c_TIMER_W'(CLK_DIV - 1);
  localparam logic [c_TIMER_W-1:0] c_HALF_M1  = c_TIMER_W'(CLK_DIV / 2 - 1);
  localparam logic [c_BIT_W-1:0]   c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
  localparam logic [0:0]           c_LAST_STP = 1'(STOP_BITS - 1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_PARITY = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;
  localparam logic [2:0] c_S_DONE   = 3'd5;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_rx;
  logic                   w_start_edge;

  logic [2:0]             r_state;
  logic [2:0]             w_next;

  logic [c_TIMER_W-1:0]   r_timer;
  logic                   w_tick;
  logic                   w_busy;
  logic                   w_done;

  logic [c_BIT_W-1:0]     r_bitcnt;
  logic [0:0]             r_stopcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_pbit;
  logic                   r_ferr;

  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr_o;
  logic                   r_ferr_o;
  logic                   r_overrun;
  logic                   w_xfer;
  logic                   w_perr;

  // --------------------------------------------------------------------------
  // Input synchroniser and start-edge detector
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
      r_prev <= w_rx;
    end
  end

  assign w_rx         = r_sync[SYNC_STAGES-1];
  // A genuine 1 -> 0 transition is required, so a line stuck low after a
  // framing error cannot retrigger reception until it has returned high.
  assign w_start_edge = r_prev & ~w_rx;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_start_edge) w_next = c_S_START;
      end
      c_S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (w_tick) w_next = w_rx ? c_S_IDLE : c_S_DATA;
      end
      c_S_DATA: begin
        if (w_tick && (r_bitcnt == c_LAST_BIT))
          w_next = (PARITY_EN != 0) ? c_S_PARITY : c_S_STOP;
      end
      c_S_PARITY: begin
        if (w_tick) w_next = c_S_STOP;
      end
      c_S_STOP: begin
        if (w_tick && (r_stopcnt == c_LAST_STP)) w_next = c_S_DONE;
      end
      c_S_DONE: begin
        w_next = c_S_IDLE;
      end
      default: begin
        w_next = c_S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = (r_state != c_S_IDLE);
    w_done = (r_state == c_S_DONE);
    case (r_state)
      c_S_START:                      w_tick = (r_timer == c_HALF_M1);
      c_S_DATA, c_S_PARITY, c_S_STOP: w_tick = (r_timer == c_FULL_M1);
      default:                        w_tick = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bit timer: restarts on every state entry and after every sample
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if ((w_next != r_state) || w_tick || (r_state == c_S_IDLE)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame datapath: shift register, counters, parity and stop capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= '0;
      r_pbit    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          r_bitcnt  <= '0;
          r_stopcnt <= '0;
          r_ferr    <= 1'b0;
        end
        c_S_DATA: begin
          if (w_tick) begin
            // Right shift: after DATA_BITS samples, bit k sits in r_shift[k].
            r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        c_S_PARITY: begin
          if (w_tick) r_pbit <= w_rx;
        end
        c_S_STOP: begin
          if (w_tick) begin
            if (!w_rx) r_ferr <= 1'b1;
            if (r_stopcnt != c_LAST_STP) r_stopcnt <= r_stopcnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_perr = (PARITY_EN != 0) &&
                  ((^r_shift) ^ r_pbit ^ (PARITY_ODD != 0));

  // --------------------------------------------------------------------------
  // Output register and valid/ready handshake
  // --------------------------------------------------------------------------
  assign w_xfer = r_valid & rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      // A word leaving in this very cycle frees the slot for the new one.
      if (!r_valid || w_xfer) begin
        r_data   <= r_shift;
        r_perr_o <= w_perr;
        r_ferr_o <= r_ferr;
        r_valid  <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr_o;
  assign overrun    = r_overrun;
  assign rx_busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Directed self-checking bench for uart_rx_param. Three receivers
//            share one clock: A = 8N1, B = 8E1, C = 9N2, all CLK_DIV = 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] line;
  logic [2:0] ready;
  logic [2:0] valid, perr, ferr, ovr, busy;
  logic [7:0] data_a, data_b;
  logic [8:0] data_c;

  uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .SYNC_STAGES(3)) u_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[0]), .rx_data(data_a),
    .rx_valid(valid[0]), .rx_ready(ready[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .overrun(ovr[0]), .rx_busy(busy[0]));

  uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .SYNC_STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[1]), .rx_data(data_b),
    .rx_valid(valid[1]), .rx_ready(ready[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .overrun(ovr[1]), .rx_busy(busy[1]));

  uart_rx_param #(.CLK_DIV(16), .DATA_BITS(9), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(2), .SYNC_STAGES(3)) u_c (
    .clk(clk), .rst_n(rst_n), .uart_rx(line[2]), .rx_data(data_c),
    .rx_valid(valid[2]), .rx_ready(ready[2]), .parity_err(perr[2]),
    .frame_err(ferr[2]), .overrun(ovr[2]), .rx_busy(busy[2]));

  // Output monitor: counts valid cycles, transfers and busy cycles, and
  // captures the word and flags at each transfer.
  logic [8:0] dvec [3];
  always_comb begin
    dvec[0] = {1'b0, data_a};
    dvec[1] = {1'b0, data_b};
    dvec[2] = data_c;
  end

  int         vcyc [3] = '{0, 0, 0};
  int         xcnt [3] = '{0, 0, 0};
  int         bcnt [3] = '{0, 0, 0};
  logic [8:0] cap_d  [3] = '{9'h0, 9'h0, 9'h0};
  logic       cap_pe [3] = '{1'b0, 1'b0, 1'b0};
  logic       cap_fe [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) vcyc[i]++;
      if (busy[i])  bcnt[i]++;
      if (valid[i] && ready[i]) begin
        xcnt[i]++;
        cap_d[i]  = dvec[i];
        cap_pe[i] = perr[i];
        cap_fe[i] = ferr[i];
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int bx, bv, bb;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives n bits of 'bits' (LSB first, start bit included) at 16 clk/bit.
  task automatic send(input int idx, input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int i = 0; i < n; i++) begin
      line[idx] = b[i];
      idle(16);
    end
  endtask

  task automatic snap(input int idx);
    bx = xcnt[idx];
    bv = vcyc[idx];
    bb = bcnt[idx];
  endtask

  initial begin
    rst_n = 1'b0;
    line  = 3'b111;
    ready = 3'b000;
    idle(3);
    rst_n = 1'b1;
    idle(5);

    // Reset state
    chk("rst_data_a",  16'(data_a),  16'h0);
    chk("rst_valid",   16'(valid),   16'h0);
    chk("rst_perr",    16'(perr),    16'h0);
    chk("rst_ferr",    16'(ferr),    16'h0);
    chk("rst_ovr",     16'(ovr),     16'h0);
    chk("rst_busy",    16'(busy),    16'h0);
    chk("rst_data_c",  16'(data_c),  16'h0);

    // 1: 0xA5 on 8N1 with ready held high
    ready[0] = 1'b1;
    snap(0);
    send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10);
    idle(20);
    chk("t1_xfers",  16'(xcnt[0] - bx), 16'd1);
    chk("t1_vcyc",   16'(vcyc[0] - bv), 16'd1);
    chk("t1_data",   16'(cap_d[0]),     16'h00A5);
    chk("t1_perr",   16'(cap_pe[0]),    16'h0);
    chk("t1_ferr",   16'(cap_fe[0]),    16'h0);
    chk("t1_ovr",    16'(ovr[0]),       16'h0);
    chk("t1_valid",  16'(valid[0]),     16'h0);

    // 2: 0x3C even parity, correct then wrong parity bit
    ready[1] = 1'b1;
    snap(1);
    send(1, {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    idle(20);
    chk("t2a_xfers", 16'(xcnt[1] - bx), 16'd1);
    chk("t2a_data",  16'(cap_d[1]),     16'h003C);
    chk("t2a_perr",  16'(cap_pe[1]),    16'h0);
    send(1, {5'd0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    idle(20);
    chk("t2b_xfers", 16'(xcnt[1] - bx), 16'd2);
    chk("t2b_data",  16'(cap_d[1]),     16'h003C);
    chk("t2b_perr",  16'(cap_pe[1]),    16'h1);
    chk("t2b_ferr",  16'(cap_fe[1]),    16'h0);

    // 3: short low glitch is a false start
    snap(0);
    line[0] = 1'b0;
    idle(4);
    line[0] = 1'b1;
    idle(40);
    chk("t3_busy_seen", 16'(bcnt[0] != bb), 16'h1);
    chk("t3_no_valid",  16'(vcyc[0] - bv),  16'd0);
    chk("t3_busy_now",  16'(busy[0]),       16'h0);
    chk("t3_ovr",       16'(ovr[0]),        16'h0);

    // 4: framing error, line held low, then recovery
    snap(0);
    send(0, {6'd0, 1'b0, 8'h55, 1'b0}, 10);
    idle(40);
    chk("t4a_xfers", 16'(xcnt[0] - bx), 16'd1);
    chk("t4a_data",  16'(cap_d[0]),     16'h0055);
    chk("t4a_ferr",  16'(cap_fe[0]),    16'h1);
    chk("t4a_busy",  16'(busy[0]),      16'h0);
    line[0] = 1'b1;
    idle(16);
    send(0, {6'd0, 1'b1, 8'h12, 1'b0}, 10);
    idle(20);
    chk("t4b_xfers", 16'(xcnt[0] - bx), 16'd2);
    chk("t4b_data",  16'(cap_d[0]),     16'h0012);
    chk("t4b_ferr",  16'(cap_fe[0]),    16'h0);

    // 5: overrun with ready low
    ready[0] = 1'b0;
    send(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
    idle(20);
    chk("t5a_valid", 16'(valid[0]),  16'h1);
    chk("t5a_data",  16'(data_a),    16'h0011);
    chk("t5a_ovr",   16'(ovr[0]),    16'h0);
    send(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
    idle(20);
    chk("t5b_valid", 16'(valid[0]),  16'h1);
    chk("t5b_data",  16'(data_a),    16'h0011);
    chk("t5b_ovr",   16'(ovr[0]),    16'h1);
    ready[0] = 1'b1;
    idle(1);
    ready[0] = 1'b0;
    idle(2);
    chk("t5c_valid", 16'(valid[0]),  16'h0);
    chk("t5c_ovr",   16'(ovr[0]),    16'h1);

    // 6: reset mid-data on 9N2, then a clean 0x1FF
    ready[2] = 1'b1;
    snap(2);
    send(2, 16'h000A, 4);
    chk("t6_busy_mid", 16'(busy[2]), 16'h1);
    rst_n   = 1'b0;
    line[2] = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    chk("t6a_no_valid", 16'(vcyc[2] - bv), 16'd0);
    chk("t6a_busy",     16'(busy[2]),      16'h0);
    chk("t6a_ovr_a",    16'(ovr[0]),       16'h0);
    send(2, {4'd0, 2'b11, 9'h1FF, 1'b0}, 12);
    idle(20);
    chk("t6b_xfers", 16'(xcnt[2] - bx), 16'd1);
    chk("t6b_data",  16'(cap_d[2]),     16'h01FF);
    chk("t6b_ferr",  16'(cap_fe[2]),    16'h0);
    chk("t6b_perr",  16'(cap_pe[2]),    16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver. It integrates the baud-rate timing, so no external baud generator or bps_start/clk_bps handshake is needed. It supports a configurable data width, optional even/odd parity and 1 or 2 stop bits, and reports framing, parity and overrun errors. Output is a valid/ready interface toward the consuming logic (FIFO or command parser).

Parameters:
CLK_DIV, 217, clk cycles per bit (25 MHz / 115200 ≈ 217); legal range 4 to 65535.
DATA_BITS, 8, data bits per frame; legal range 5 to 9.
PARITY_EN, 0, 1 = a parity bit follows the data.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 3, synchroniser depth on uart_rx; minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial line, idle high, LSB first
rx_data  out  DATA_BITS  received word, stable while rx_valid = 1
rx_valid  out  1  word available; held high until accepted
rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready
parity_err  out  1  parity mismatch on the word in rx_data; qualified by rx_valid
frame_err  out  1  a stop bit was sampled low on the word in rx_data; qualified by rx_valid
overrun  out  1  sticky; a frame completed while rx_valid was still pending
rx_busy  out  1  high from start-bit detection until the end of the last stop sample

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous, active low.
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE; all counters = 0.
  - rx_data = 0; rx_valid, parity_err, frame_err, overrun, rx_busy = 0.
  - Reset mid-frame aborts the frame with no output.
- Synchroniser: uart_rx passes through SYNC_STAGES flops. A start edge is registered when the last stage = 0 and the previous sampled value = 1.
- Bit timer: a CLK_DIV-wide counter, reloaded on every state entry.
- IDLE:
  - On a start edge, go to START and set rx_busy = 1.
- START:
  - Wait CLK_DIV/2 (integer division) cycles, then sample.
  - Sample = 0: go to DATA.
  - Sample = 1: false start. Return to IDLE, rx_busy = 0, no output, no error.
- DATA:
  - Sample every CLK_DIV cycles, DATA_BITS times.
  - Shift LSB first: bit k lands in shift[k].
- PARITY (only when PARITY_EN = 1):
  - One sample CLK_DIV cycles after the last data sample.
  - Error when the XOR of the data bits, XOR the parity bit, XOR PARITY_ODD is 1.
- STOP:
  - STOP_BITS samples, each CLK_DIV apart.
  - Any stop sample = 0 sets the frame error.
  - No early exit: all stop samples are always taken.
- Completion (the cycle after the last stop sample):
  - Load rx_data and the error flags.
  - Set rx_valid = 1, set rx_busy = 0, return to IDLE.
  - A frame with frame_err is still delivered.
- Re-arm: after a framing error with the line held low, IDLE re-arms only after the line returns high, because a start edge requires a 1 → 0 transition.
- Handshake:
  - A transfer occurs in any cycle with rx_valid & rx_ready; rx_valid clears on the next edge.
  - rx_ready may stay high permanently.
  - rx_ready has no effect while rx_valid = 0.
- Overrun:
  - Completion with rx_valid = 1 and no transfer in the same cycle: keep the old rx_data and flags, discard the new word, set overrun = 1.
  - Completion in the same cycle as a transfer: load the new word, no overrun.
  - overrun clears only on reset.
- Latency: rx_valid rises 1 clk after the mid-point sample of the final stop bit. That is about (0.5 + 1 + DATA_BITS + PARITY_EN + STOP_BITS − 1) × CLK_DIV + SYNC_STAGES + 1 cycles after the falling line edge.
- Widths:
  - The bit counter holds 0 to DATA_BITS.
  - Stop-bit and data-bit counts are compared exactly; no wrap-around is permitted.

Test Plan:
1. CLK_DIV=16, DATA_BITS=8, no parity, 1 stop; send 0xA5 with rx_ready=1 → rx_valid high for 1 cycle, rx_data=0xA5, parity_err=0, frame_err=0, overrun=0.
2. PARITY_EN=1, even; send 0x3C with parity bit 0 → rx_data=0x3C, parity_err=0. Resend 0x3C with parity bit 1 → parity_err=1.
3. Drive uart_rx low for 4 cycles (< CLK_DIV/2), then high → rx_busy pulses, rx_valid never asserts, no error flags.
4. Send 0x55 with stop bit = 0 → rx_valid=1, rx_data=0x55, frame_err=1. Hold the line low 40 cycles, then high, then send 0x12 → received correctly.
5. rx_ready=0; send 0x11 then 0x22 → rx_data stays 0x11, overrun=1. Pulse rx_ready → rx_valid=0; overrun stays 1.
6. DATA_BITS=9, STOP_BITS=2; assert rst_n=0 mid-data for 3 cycles, then send 0x1FF → no word from the aborted frame; rx_data=0x1FF, frame_err=0.
